// File: rtl/instr_encoder_loader.sv
// Symbolic-instruction encoder and instruction-memory loader.
// Encodes mnemonic + fields into 32-bit MIPS words, writes them to sequential
// imem addresses and holds the core in reset (cpu_run=0) until loading completes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting instructions, one write per accepted legal instruction
// DONE   | last instruction written, core released (cpu_run=1)
// ERR    | illegal op or overflow seen, core held, errors sticky until start
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              cpu_run,
    output logic              err_illegal,
    output logic              err_full
);

    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE      = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_JR   = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_ORI  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_J    = 4'd12;
    localparam logic [3:0] OP_JAL  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        pend_last;
    logic        full;
    logic        can_accept;
    logic        xfer;
    logic        load_enter;
    logic        set_illegal;
    logic        set_full;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign full       = (count == CAPACITY);
    // No new instruction once memory is full or the final one is still in flight.
    assign can_accept = !full && !pend_last;
    assign xfer       = in_valid && in_ready;

    // Encode the presented fields into a MIPS word; imm bits are placed raw.
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            OP_SUB:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            OP_AND:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            OP_OR:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            OP_SLT:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            OP_JR:   enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
            OP_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            OP_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            OP_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            OP_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm[15:0]};
            OP_ORI:  enc_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
            OP_LUI:  enc_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
            OP_J:    enc_word = {6'b000010, in_imm};
            OP_JAL:  enc_word = {6'b000011, in_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, handshake ready and error/entry strobes.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        load_enter  = 1'b0;
        set_illegal = 1'b0;
        set_full    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt  = S_LOAD;
                    load_enter = 1'b1;
                end
            end
            S_LOAD: begin
                in_ready = can_accept;
                if (pend_last) begin
                    // Final write is on imem this cycle; release the core next.
                    state_nxt = S_DONE;
                end else if (in_valid && can_accept && !enc_legal) begin
                    set_illegal = 1'b1;
                    state_nxt   = S_ERR;
                end else if (in_valid && full) begin
                    set_full  = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write pipeline, word counter, core-release flag and sticky errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_we     <= 1'b0;
            imem_addr   <= BASE;
            imem_wdata  <= 32'h0000_0000;
            count       <= '0;
            cpu_run     <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            pend_last   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (load_enter) begin
                imem_addr   <= BASE;
                count       <= '0;
                cpu_run     <= 1'b0;
                err_illegal <= 1'b0;
                err_full    <= 1'b0;
                pend_last   <= 1'b0;
            end else begin
                if (xfer && enc_legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BASE + count[ADDR_W-1:0];
                    imem_wdata <= enc_word;
                    count      <= count + ONE;
                    pend_last  <= in_last;
                end
                if (state == S_LOAD && pend_last) begin
                    pend_last <= 1'b0;
                    cpu_run   <= 1'b1;
                end
                if (set_illegal) begin
                    err_illegal <= 1'b1;
                end
                if (set_full) begin
                    err_full <= 1'b1;
                end
            end
        end
    end

endmodule
